// File: rtl/xor_parity_arbiter.sv
// xor_parity_arbiter: round-robin scheduler sharing one 4-input XOR reduction
// stage among NREQ requesters. The winning word is latched and folded one
// nibble per cycle into a parity accumulator. The even-parity bit is then
// presented with the index of the requester that owns it.
module xor_parity_arbiter #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 16,
    parameter int ID_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WORD_W-1:0] data,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic                   valid,
    output logic                   parity,
    output logic [ID_W-1:0]        id
);

    localparam int NIB_N = WORD_W / 4;
    localparam int CNT_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // The shared reduction stage: parity of one nibble.
    function automatic logic xor4(input logic [3:0] nib);
        return nib[0] ^ nib[1] ^ nib[2] ^ nib[3];
    endfunction

    state_t              state_q;
    logic [WORD_W-1:0]   sr_q;
    logic                acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     gid_q;
    logic                busy_q;
    logic                valid_q;
    logic                parity_q;
    logic [ID_W-1:0]     id_q;

    logic                win_found_s;
    logic [ID_W-1:0]     win_idx_s;
    logic [WORD_W-1:0]   win_word_s;
    logic [NREQ-1:0]     grant_s;
    logic                acc_d;
    logic [ID_W-1:0]     ptr_d;

    // Round-robin scan of req starting at ptr, wrapping NREQ-1 back to 0.
    always_comb begin : arb_scan
        int idx_v;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        idx_v       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v = int'(ptr_q) + k;
            if (idx_v >= NREQ) begin
                idx_v = idx_v - NREQ;
            end else begin
                idx_v = idx_v;
            end
            if (!win_found_s && req[idx_v]) begin
                win_found_s = 1'b1;
                win_idx_s   = ID_W'(idx_v);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Select the winner's word and form the one-hot grant; reset suppresses grant.
    always_comb begin
        win_word_s = '0;
        grant_s    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx_s == ID_W'(i)) begin
                win_word_s = data[i*WORD_W +: WORD_W];
                grant_s[i] = (state_q == ST_IDLE) && win_found_s && !reset;
            end else begin
                grant_s[i] = 1'b0;
            end
        end
    end

    // Next accumulator value and the pointer position after the current owner.
    always_comb begin
        acc_d = acc_q ^ xor4(sr_q[3:0]);
        if (gid_q == ID_W'(NREQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gid_q + ID_W'(1);
        end
    end

    // Main FSM: latch winner, fold nibbles, present result, advance pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            acc_q    <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            gid_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            parity_q <= 1'b0;
            id_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (win_found_s) begin
                        sr_q    <= win_word_s;
                        acc_q   <= 1'b0;
                        cnt_q   <= '0;
                        gid_q   <= win_idx_s;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc_q <= acc_d;
                    sr_q  <= sr_q >> 3'd4;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        // Result registers capture the final fold so they
                        // are valid during DONE and hold afterwards.
                        parity_q <= acc_d;
                        id_q     <= gid_q;
                        valid_q  <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    ptr_q   <= ptr_d;
                    state_q <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant  = grant_s;
    assign busy   = busy_q;
    assign valid  = valid_q;
    assign parity = parity_q;
    assign id     = id_q;

endmodule

// File: tb/tb_xor_parity_arbiter.sv
// Scoreboard bench for xor_parity_arbiter: the driver pushes expected grants
// and results into queues; a monitor pops and compares on grant / valid.
module tb_xor_parity_arbiter;

    localparam int NREQ   = 4;
    localparam int WORD_W = 16;
    localparam int ID_W   = 2;
    localparam int LAT    = WORD_W / 4 + 1;

    typedef struct {
        logic [NREQ-1:0] g;
        int              gap;
    } gexp_t;

    typedef struct {
        logic            p;
        logic [ID_W-1:0] i;
    } rexp_t;

    logic                   clk;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ*WORD_W-1:0] data;
    logic [NREQ-1:0]        grant;
    logic                   busy;
    logic                   valid;
    logic                   parity;
    logic [ID_W-1:0]        id;

    int checks;
    int errors;
    int cyc;
    int last_grant_cyc;
    gexp_t exp_g_q[$];
    rexp_t exp_r_q[$];

    xor_parity_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W), .ID_W(ID_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .data   (data),
        .grant  (grant),
        .busy   (busy),
        .valid  (valid),
        .parity (parity),
        .id     (id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int idx, input logic [WORD_W-1:0] w);
        data[idx*WORD_W +: WORD_W] = w;
    endtask

    task automatic push_g(input logic [NREQ-1:0] g, input int gap);
        gexp_t e;
        e.g   = g;
        e.gap = gap;
        exp_g_q.push_back(e);
    endtask

    task automatic push_r(input logic p, input logic [ID_W-1:0] i);
        rexp_t e;
        e.p = p;
        e.i = i;
        exp_r_q.push_back(e);
    endtask

    // Single requester transaction: request at T, drop at T+1, back in IDLE at T+6.
    task automatic single(input int idx, input logic [WORD_W-1:0] w, input logic p);
        set_word(idx, w);
        push_g(NREQ'(1) << idx, 0);
        push_r(p, ID_W'(idx));
        req = NREQ'(1) << idx;
        step(1);
        req = '0;
        step(5);
    endtask

    // Monitor: compare grants and results against the scoreboard queues.
    always @(negedge clk) begin
        gexp_t ge;
        rexp_t re;
        if (grant !== '0) begin
            if (exp_g_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant_unexpected got %b expected none", grant);
            end else begin
                ge = exp_g_q.pop_front();
                chk("grant", 32'(grant), 32'(ge.g));
                chk("busy_at_grant", 32'(busy), 32'd0);
                if (ge.gap != 0) begin
                    chk("grant_spacing", 32'(cyc - last_grant_cyc), 32'(ge.gap));
                end
            end
            last_grant_cyc = cyc;
        end
        if (valid === 1'b1) begin
            if (exp_r_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid_unexpected got id %0d parity %0b expected none", id, parity);
            end else begin
                re = exp_r_q.pop_front();
                chk("parity", 32'(parity), 32'(re.p));
                chk("id", 32'(id), 32'(re.i));
                chk("busy_at_valid", 32'(busy), 32'd1);
                chk("latency", 32'(cyc - last_grant_cyc), 32'(LAT));
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        last_grant_cyc = 0;
        reset = 1'b1;
        req   = '1;
        data  = '0;

        // Reset state, with requests asserted: reset wins, no grant.
        step(2);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_parity", 32'(parity), 32'd0);
        chk("rst_id", 32'(id), 32'd0);
        reset = 1'b0;
        req   = '0;
        step(1);

        // Single request, busy window check, then parity patterns on requester 0.
        set_word(0, 16'h0001);
        push_g(4'b0001, 0);
        push_r(1'b1, 2'd0);
        req = 4'b0001;
        step(1);
        req = '0;
        chk("busy_T1", 32'(busy), 32'd1);
        step(4);
        chk("busy_T5", 32'(busy), 32'd1);
        chk("valid_T5", 32'(valid), 32'd1);
        step(1);
        chk("busy_T6", 32'(busy), 32'd0);
        chk("valid_T6", 32'(valid), 32'd0);
        chk("parity_hold", 32'(parity), 32'd1);
        single(0, 16'hFFFF, 1'b0);
        single(0, 16'h8000, 1'b1);
        single(0, 16'h1234, 1'b1);
        single(0, 16'h0000, 1'b0);

        // Fairness from a freshly reset pointer with all requests held.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        set_word(0, 16'h0001);
        set_word(1, 16'h0003);
        set_word(2, 16'h1234);
        set_word(3, 16'h00FF);
        push_g(4'b0001, 0); push_r(1'b1, 2'd0);
        push_g(4'b0010, 6); push_r(1'b0, 2'd1);
        push_g(4'b0100, 6); push_r(1'b1, 2'd2);
        push_g(4'b1000, 6); push_r(1'b0, 2'd3);
        push_g(4'b0001, 6); push_r(1'b1, 2'd0);
        req = 4'b1111;
        step(25);
        req = '0;
        step(5);

        // Pointer wrap: serve requester 3, then 1001 goes to 0 first, then 3.
        single(3, 16'h8001, 1'b0);
        push_g(4'b0001, 0); push_r(1'b1, 2'd0);
        push_g(4'b1000, 6); push_r(1'b0, 2'd3);
        req = 4'b1001;
        step(7);
        req = '0;
        step(5);

        // Reset at T+3 of a grant to requester 2: word discarded, pointer cleared.
        set_word(2, 16'h0007);
        set_word(1, 16'h0013);
        push_g(4'b0100, 0);
        req = 4'b0100;
        step(1);
        req = '0;
        step(2);
        reset = 1'b1;
        req   = 4'b0110;
        push_g(4'b0010, 0);
        push_r(1'b1, 2'd1);
        step(1);
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_parity", 32'(parity), 32'd0);
        chk("midrst_id", 32'(id), 32'd0);
        step(1);
        req = '0;
        step(5);

        // Data and req change right after grant: latched word is used.
        set_word(0, 16'h00F1);
        push_g(4'b0001, 0);
        push_r(1'b1, 2'd0);
        req = 4'b0001;
        step(1);
        req = '0;
        set_word(0, 16'h0000);
        step(5);

        step(4);
        chk("grants_left", 32'(exp_g_q.size()), 32'd0);
        chk("results_left", 32'(exp_r_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_parity_arbiter.md
# xor_parity_arbiter

Shared-parity scheduler that time-multiplexes a single 4-input XOR reduction stage among NREQ requesters. Each requester presents a WORD_W-bit word and holds a request. The block arbitrates round-robin, latches the winning word, and feeds it nibble by nibble through the 4-input XOR stage, accumulating parity. It returns the even-parity bit (XOR of all word bits) tagged with the requester index. It sits between the parity consumers and the XOR gate primitive.

## Interface
- NREQ, 4, number of requesters; 2..8.
- WORD_W, 16, word width; a multiple of 4, minimum 4.
- ID_W, 2, index width; ceil(log2(NREQ)), minimum 1.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  input  NREQ  request vector; bit i high means requester i has a word pending.
- data  input  NREQ*WORD_W  flattened words; requester i occupies bits [i*WORD_W +: WORD_W].
- grant  output  NREQ  one-hot acknowledge, high for one cycle when the word is latched.
- busy  output  1  high while a word is being processed (SHIFT or DONE).
- valid  output  1  one-cycle pulse; parity and id are valid.
- parity  output  1  XOR of all WORD_W bits of the granted word.
- id  output  ID_W  index of the requester whose result is presented.

## Operation
- The reduction stage is combinational: nib[0]^nib[1]^nib[2]^nib[3], applied to the low nibble of the shift register.
- Internal state:
  - shift register sr, WORD_W bits.
  - accumulator acc, 1 bit.
  - nibble counter cnt, ceil(log2(WORD_W/4)) bits, minimum 1.
  - priority pointer ptr, ID_W bits.
  - latched index gid, ID_W bits.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Scan req starting at ptr, ascending with wrap NREQ-1 to 0. The first set bit wins as index w.
  - Then: grant[w]=1; sr<=data word w; acc<=0; cnt<=0; gid<=w; go to SHIFT.
  - With no request set, stay in IDLE; all outputs stay low.
- SHIFT:
  - Each cycle: acc<=acc^xor4(sr[3:0]); sr<=sr>>4; cnt<=cnt+1.
  - On the cycle where cnt==WORD_W/4-1, go to DONE.
- DONE:
  - valid=1; parity=acc; id=gid.
  - ptr<=gid+1, modulo NREQ (NREQ-1 wraps to 0).
  - Go to IDLE.
- req and data are ignored outside IDLE. A requester may drop req or change data any time after its grant pulse.
- A requester still holding req after DONE is re-arbitrated normally. With ptr advanced, every requester is served within NREQ grants.
- req bits at index >= NREQ do not exist. A non-power-of-two NREQ never produces id >= NREQ.

## Timing
- Reset values:
  - Outputs: grant=0, busy=0, valid=0, parity=0, id=0.
  - Internal: state=IDLE, ptr=0, acc=0, cnt=0, sr=0.
- Grant cycle T (IDLE with req sampled):
  - grant is driven combinationally from req and ptr in cycle T.
  - The latch happens on the T->T+1 edge.
- SHIFT occupies T+1 through T+WORD_W/4; busy=1.
- DONE at T+WORD_W/4+1: valid=1, busy=1. Latency from grant to valid is WORD_W/4+1 cycles; 5 at the default width.
- The earliest next grant is the cycle after DONE. Throughput is one word per WORD_W/4+2 cycles; 6 at the default width.
- parity and id are registered and hold their values after valid drops, until the next DONE. Consumers must sample them only when valid=1.
- Reset mid-operation:
  - Reset in any state returns to IDLE on the next edge and sets ptr=0.
  - An in-flight word is discarded: no valid is issued for it, and its requester must re-request.
- Reset and req together: reset wins; no grant is issued in that cycle.

## Test plan
- Single request: reset, then req=0001, data[15:0]=0x0001. Expect grant=0001 at T, busy high T+1..T+5, valid=1 at T+5 with parity=1, id=0.
- Parity values on requester 0:
  - 0xFFFF -> parity 0.
  - 0x8000 -> parity 1 (MSB nibble is processed last).
  - 0x1234 -> parity 1.
  - 0x0000 -> parity 0.
- Fairness: hold req=1111 continuously. Expect the grant sequence 0001, 0010, 0100, 1000, 0001, spaced 6 cycles apart, with id matching on each valid.
- Pointer wrap: after serving requester 3, assert req=1001. Expect grant=0001 (requester 0 first), then 1000 on the next grant.
- Reset mid-operation: assert reset at T+3 of a grant to requester 2. Expect no valid pulse and all outputs 0. After reset with req=0110, expect grant=0010 (ptr reset to 0).
- Data changes after grant: change data word 0 and drop req at T+1. Expect parity computed from the word latched at T.
